pipelined_acc_alu: RTL and testbench
====================================

// Module: pipelined_acc_alu
// PURPOSE
//  Parametrised 2-stage pipelined ALU with valid/ready handshakes, status flags and an internal
//  accumulator that can replace operand A. It is the successor to the combinational 16-bit/8-op
//  ALU and is intended to sit between a register-file read port and the writeback stage.
// PARAMETERS
//  WIDTH      16  operand/result width in bits (>= 4)
//  ACC_RESET  0   value loaded into the accumulator on Reset (WIDTH bits)
// PORTS
//  Clock     in   1      rising-edge clock
//  Reset     in   1      synchronous, active-high reset
//  InValid   in   1      an operation is presented on A/B/S/UseAcc/AccWr
//  InReady   out  1      block can accept; transfer occurs when InValid & InReady
//  A         in   WIDTH  operand A (ignored when UseAcc=1)
//  B         in   WIDTH  operand B
//  S         in   3      operation select
//  UseAcc    in   1      1: use accumulator in place of A
//  AccWr     in   1      1: write the result of this op into the accumulator
//  OutValid  out  1      Q and flags hold a valid result
//  OutReady  in   1      consumer accepts; result retires when OutValid & OutReady
//  Q         out  WIDTH  result
//  Zero      out  1      Q == 0
//  Carry     out  1      ADD carry-out / SUB borrow (A<B unsigned); 0 for other ops
//  Overflow  out  1      signed overflow for ADD/SUB; 0 for other ops
//  Negative  out  1      Q[WIDTH-1]
//  Acc       out  WIDTH  current accumulator value
// BEHAVIOUR
//  Ops (S): 0 ADD A+B | 1 SUB A-B | 2 AND | 3 OR | 4 XOR |
//    5 SHL A<<B[$clog2(WIDTH)-1:0] | 6 SHR logical, same amount | 7 PASS B.
//    Results are truncated to WIDTH; shift amounts use only the low $clog2(WIDTH) bits of B.
//  Stage 1 (S1): on accept, registers A, B, S, UseAcc and AccWr, and sets s1_valid.
//  Stage 2 (S2): computes from the S1 registers and registers Q and the flags; OutValid = s2_valid.
//  Advance rules: s2_adv = !OutValid | OutReady; InReady = !s1_valid | s2_adv (combinational).
//    On an edge where s2_adv holds, S2 loads S1 (s2_valid <= s1_valid).
//    S1 loads a new input if one is accepted; otherwise s1_valid clears once S1 has moved to S2.
//  Latency: 2 cycles from accept to OutValid with no stall; 1 op/cycle sustained throughput.
//  Stall: while OutValid & !OutReady, Q, the flags and S1 hold; at most 2 ops are in flight.
//    InReady drops only when S1 and S2 are both full and the output is stalled.
//  Accumulator: the operand is read from Acc at the S1->S2 edge. When a valid op with AccWr=1
//    moves into S2, Acc <= result on that same edge. Back-to-back UseAcc ops therefore chain
//    with no bubble or hazard. Acc never changes in any other case.
//  Flags apply only to valid results; registered alongside Q.
//  Reset (dominates all inputs, including mid-operation): s1_valid=0, OutValid=0, Q=0, all
//    flags=0, Acc=ACC_RESET, InReady=1 in the cycle after Reset. In-flight ops are discarded
//    and never produce output or update Acc.
//  Inputs are don't-care when InValid=0. Accepting an input and retiring a result on the same
//  edge is legal and loses nothing.
// TESTING
//  1 WIDTH=16, OutReady=1, ADD A=16'hFFFF B=1 -> 2 cycles later Q=0, Zero=1, Carry=1, Overflow=0.
//  2 ADD A=16'h7FFF B=1 -> Q=16'h8000, Overflow=1, Negative=1. SUB A=3 B=5 -> Q=16'hFFFE, Carry=1.
//  3 Chain: ACC_RESET=0; 4 back-to-back UseAcc=1, AccWr=1 ADD B=5 ->
//    Q=5,10,15,20 on consecutive cycles, Acc=20.
//  4 Backpressure: 3 ops offered, OutReady=0 for 4 cycles -> InReady drops after 2 accepts,
//    Q holds the first result. Then OutReady=1 -> all 3 results appear in order, none lost or duplicated.
//  5 Shifts: SHL A=1 B=16'h0013 (amount 3) -> Q=8; SHR A=16'h8000 B=15 -> Q=1; PASS B=16'hABCD -> Q=16'hABCD.
//  6 Reset asserted with 2 ops in flight and Acc=20 -> next cycle OutValid=0, Acc=ACC_RESET,
//    InReady=1; no stale result ever appears. Repeat all cases at WIDTH=8.

Source files
------------

// File: rtl/pipelined_acc_alu_if.sv
// Operand/result bundle between the register-file read port, the pipelined ALU and writeback.
// master drives operations and accepts results; slave is the ALU.
interface pipelined_acc_alu_if #(
    parameter int WIDTH = 16
);
    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       s;
    logic             use_acc;
    logic             acc_wr;
    logic             out_vld;
    logic             out_rdy;
    logic [WIDTH-1:0] q;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             negative;
    logic [WIDTH-1:0] acc;

    modport master (
        output in_vld, a, b, s, use_acc, acc_wr, out_rdy,
        input  in_rdy, out_vld, q, zero, carry, overflow, negative, acc
    );

    modport slave (
        input  in_vld, a, b, s, use_acc, acc_wr, out_rdy,
        output in_rdy, out_vld, q, zero, carry, overflow, negative, acc
    );
endinterface

// File: rtl/pipelined_acc_alu.sv
// Purpose: 2-stage ALU (8 ops, ZCVN flags) with an accumulator that can stand in for operand A.
// Latency: 2 cycles accept->out_vld, 1 op/cycle sustained.
// Backpressure: out stall holds Q/flags/S1; in_rdy drops only when both stages full and stalled.
module pipelined_acc_alu #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
    input logic               clk,
    input logic               rst,
    pipelined_acc_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    typedef struct packed {
        op_e              op;
        logic             use_acc;
        logic             acc_wr;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } op_t;

    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
        logic negative;
    } flags_t;

    op_t              s1_op;
    logic             s1_vld;
    logic             s2_vld;
    logic [WIDTH-1:0] q_r;
    flags_t           flags_r;
    logic [WIDTH-1:0] acc_r;

    logic             s2_adv;
    logic             accept;
    logic [WIDTH-1:0] opa;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res;
    flags_t           flags_c;

    assign s2_adv     = !s2_vld || bus.out_rdy;
    assign bus.in_rdy = !s1_vld || s2_adv;
    assign accept     = bus.in_vld && bus.in_rdy;

    // Accumulator is read as S1 moves to S2, the same edge a preceding AccWr op lands, so chains need no bypass.
    always_comb begin
        opa      = s1_op.use_acc ? acc_r : s1_op.a;
        sum      = {1'b0, opa} + {1'b0, s1_op.b};
        diff     = {1'b0, opa} - {1'b0, s1_op.b};
        shamt    = s1_op.b[SHW-1:0];
        res      = '0;
        flags_c  = '0;
        case (s1_op.op)
            OP_ADD: begin
                res              = sum[WIDTH-1:0];
                flags_c.carry    = sum[WIDTH];
                flags_c.overflow = (opa[WIDTH-1] == s1_op.b[WIDTH-1]) &&
                                   (res[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SUB: begin
                res              = diff[WIDTH-1:0];
                flags_c.carry    = diff[WIDTH];
                flags_c.overflow = (opa[WIDTH-1] != s1_op.b[WIDTH-1]) &&
                                   (res[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_AND:  res = opa & s1_op.b;
            OP_OR:   res = opa | s1_op.b;
            OP_XOR:  res = opa ^ s1_op.b;
            OP_SHL:  res = opa << shamt;
            OP_SHR:  res = opa >> shamt;
            OP_PASS: res = s1_op.b;
            default: res = s1_op.b;
        endcase
        flags_c.zero     = (res == '0);
        flags_c.negative = res[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_op   <= '0;
            s2_vld  <= 1'b0;
            q_r     <= '0;
            flags_r <= '0;
            acc_r   <= ACC_RESET;
        end else begin
            if (s2_adv) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    q_r     <= res;
                    flags_r <= flags_c;
                    if (s1_op.acc_wr) begin
                        acc_r <= res;
                    end
                end
            end
            if (accept) begin
                s1_vld <= 1'b1;
                s1_op  <= '{op: op_e'(bus.s), use_acc: bus.use_acc, acc_wr: bus.acc_wr,
                           a: bus.a, b: bus.b};
            end else if (s2_adv) begin
                s1_vld <= 1'b0;
            end
        end
    end

    assign bus.out_vld  = s2_vld;
    assign bus.q        = q_r;
    assign bus.zero     = flags_r.zero;
    assign bus.carry    = flags_r.carry;
    assign bus.overflow = flags_r.overflow;
    assign bus.negative = flags_r.negative;
    assign bus.acc      = acc_r;
endmodule

// File: tb/tb_pipelined_acc_alu.sv
// Bench for pipelined_acc_alu: 16-bit and 8-bit instances driven in lockstep from one stimulus,
// directed vector table plus chain, backpressure and mid-flight reset sequences.
module tb_pipelined_acc_alu;
    localparam logic [2:0] T_ADD = 3'd0, T_SUB = 3'd1, T_AND = 3'd2, T_OR = 3'd3,
                           T_XOR = 3'd4, T_SHL = 3'd5, T_SHR = 3'd6, T_PASS = 3'd7;
    localparam int NV = 14;

    logic        clk;
    logic        rst;
    logic        in_vld;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  s;
    logic        use_acc;
    logic        acc_wr;
    logic        out_rdy;

    int checks   = 0;
    int failures = 0;

    pipelined_acc_alu_if #(.WIDTH(16)) if16 ();
    pipelined_acc_alu_if #(.WIDTH(8))  if8 ();

    assign if16.in_vld  = in_vld;
    assign if16.a       = a;
    assign if16.b       = b;
    assign if16.s       = s;
    assign if16.use_acc = use_acc;
    assign if16.acc_wr  = acc_wr;
    assign if16.out_rdy = out_rdy;
    assign if8.in_vld   = in_vld;
    assign if8.a        = a[7:0];
    assign if8.b        = b[7:0];
    assign if8.s        = s;
    assign if8.use_acc  = use_acc;
    assign if8.acc_wr   = acc_wr;
    assign if8.out_rdy  = out_rdy;

    pipelined_acc_alu #(.WIDTH(16), .ACC_RESET(16'h0000)) dut16 (.clk(clk), .rst(rst), .bus(if16));
    pipelined_acc_alu #(.WIDTH(8),  .ACC_RESET(8'h00))    dut8  (.clk(clk), .rst(rst), .bus(if8));

    logic [3:0] f16;
    logic [3:0] f8;
    assign f16 = {if16.zero, if16.carry, if16.overflow, if16.negative};
    assign f8  = {if8.zero, if8.carry, if8.overflow, if8.negative};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Retired results, {q, ZCVN}
    logic [19:0] got16[$];
    logic [11:0] got8[$];
    always @(negedge clk) begin
        if (if16.out_vld && out_rdy) got16.push_back({if16.q, f16});
        if (if8.out_vld && out_rdy)  got8.push_back({if8.q, f8});
    end

    typedef struct {
        logic [2:0]  s;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q16;
        logic [3:0]  f16;
        logic [7:0]  q8;
        logic [3:0]  f8;
    } vec_t;
    vec_t vt[NV];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic send(input logic [2:0] ss, input logic [15:0] aa, input logic [15:0] bb,
                        input logic ua, input logic aw);
        int n;
        @(posedge clk); #1;
        in_vld = 1'b1; s = ss; a = aa; b = bb; use_acc = ua; acc_wr = aw;
        n = 0;
        @(negedge clk);
        while (!if16.in_rdy && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", (n < 10), 1);
        @(posedge clk); #1;
        in_vld = 1'b0;
    endtask

    task automatic wait_res(output bit ok);
        int n;
        n = 0;
        while ((got16.size() == 0 || got8.size() == 0) && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        ok = (got16.size() != 0 && got8.size() != 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        logic [19:0] r16;
        logic [11:0] r8;

        //           s       a         b         q16       ZCVN     q8     ZCVN
        vt[0]  = '{T_ADD,  16'hFFFF, 16'h0001, 16'h0000, 4'b1100, 8'h00, 4'b1100};
        vt[1]  = '{T_ADD,  16'h7FFF, 16'h0001, 16'h8000, 4'b0011, 8'h00, 4'b1100};
        vt[2]  = '{T_ADD,  16'h007F, 16'h0001, 16'h0080, 4'b0000, 8'h80, 4'b0011};
        vt[3]  = '{T_SUB,  16'h0003, 16'h0005, 16'hFFFE, 4'b0101, 8'hFE, 4'b0101};
        vt[4]  = '{T_SUB,  16'h8000, 16'h0001, 16'h7FFF, 4'b0010, 8'hFF, 4'b0101};
        vt[5]  = '{T_SUB,  16'h0005, 16'h0005, 16'h0000, 4'b1000, 8'h00, 4'b1000};
        vt[6]  = '{T_AND,  16'hF0F0, 16'h3CFF, 16'h30F0, 4'b0000, 8'hF0, 4'b0001};
        vt[7]  = '{T_OR,   16'h1200, 16'h0034, 16'h1234, 4'b0000, 8'h34, 4'b0000};
        vt[8]  = '{T_XOR,  16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000, 8'h00, 4'b1000};
        vt[9]  = '{T_SHL,  16'h0001, 16'h0013, 16'h0008, 4'b0000, 8'h08, 4'b0000};
        vt[10] = '{T_SHL,  16'h0001, 16'h0019, 16'h0200, 4'b0000, 8'h02, 4'b0000};
        vt[11] = '{T_SHR,  16'h8000, 16'h000F, 16'h0001, 4'b0000, 8'h00, 4'b1000};
        vt[12] = '{T_SHR,  16'h0080, 16'h0007, 16'h0001, 4'b0000, 8'h01, 4'b0000};
        vt[13] = '{T_PASS, 16'h1234, 16'hABCD, 16'hABCD, 4'b0001, 8'hCD, 4'b0001};

        rst = 1'b1; in_vld = 1'b0; a = '0; b = '0; s = '0;
        use_acc = 1'b0; acc_wr = 1'b0; out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_vld16", if16.out_vld, 0);
        chk("rst_in_rdy16",  if16.in_rdy, 1);
        chk("rst_q16",       if16.q, 0);
        chk("rst_flags16",   f16, 0);
        chk("rst_acc16",     if16.acc, 0);
        chk("rst_out_vld8",  if8.out_vld, 0);
        chk("rst_in_rdy8",   if8.in_rdy, 1);
        chk("rst_q8",        if8.q, 0);
        chk("rst_flags8",    f8, 0);
        chk("rst_acc8",      if8.acc, 0);

        for (int i = 0; i < NV; i++) begin
            got16.delete();
            got8.delete();
            send(vt[i].s, vt[i].a, vt[i].b, 1'b0, 1'b0);
            wait_res(ok);
            chk($sformatf("vec%0d_result_seen", i), ok, 1);
            if (ok) begin
                r16 = got16.pop_front();
                r8  = got8.pop_front();
                chk($sformatf("vec%0d_q16", i),     r16[19:4], vt[i].q16);
                chk($sformatf("vec%0d_flags16", i), r16[3:0],  vt[i].f16);
                chk($sformatf("vec%0d_q8", i),      r8[11:4],  vt[i].q8);
                chk($sformatf("vec%0d_flags8", i),  r8[3:0],   vt[i].f8);
            end
        end
        @(negedge clk);
        chk("table_acc16_untouched", if16.acc, 0);
        chk("table_acc8_untouched",  if8.acc, 0);

        // Accumulator chain: four back-to-back acc += 5, A must be ignored
        @(posedge clk); #1;
        in_vld = 1'b1; s = T_ADD; a = 16'hFFFF; b = 16'h0005; use_acc = 1'b1; acc_wr = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 5) begin
                chk($sformatf("chain%0d_out_vld16", c), if16.out_vld, 1);
                chk($sformatf("chain%0d_q16", c),       if16.q, 5 * (c - 1));
                chk($sformatf("chain%0d_out_vld8", c),  if8.out_vld, 1);
                chk($sformatf("chain%0d_q8", c),        if8.q, 5 * (c - 1));
            end else begin
                chk($sformatf("chain%0d_idle16", c), if16.out_vld, 0);
                chk($sformatf("chain%0d_idle8", c),  if8.out_vld, 0);
            end
            if (c < 4) chk($sformatf("chain%0d_in_rdy", c), if16.in_rdy, 1);
            @(posedge clk); #1;
            if (c == 3) begin
                in_vld = 1'b0; use_acc = 1'b0; acc_wr = 1'b0;
            end
        end
        @(negedge clk);
        chk("chain_acc16", if16.acc, 20);
        chk("chain_acc8",  if8.acc, 20);

        // Backpressure: three ops offered with the output stalled
        got16.delete();
        got8.delete();
        @(posedge clk); #1;
        out_rdy = 1'b0; in_vld = 1'b1; s = T_PASS; b = 16'h0011;
        @(negedge clk);
        chk("bp_in_rdy_first", if16.in_rdy, 1);
        @(posedge clk); #1;
        b = 16'h0022;
        @(negedge clk);
        chk("bp_in_rdy_second", if16.in_rdy, 1);
        @(posedge clk); #1;
        b = 16'h0033;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("bp_stall%0d_in_rdy16", k), if16.in_rdy, 0);
            chk($sformatf("bp_stall%0d_in_rdy8", k),  if8.in_rdy, 0);
            chk($sformatf("bp_stall%0d_out_vld", k),  if16.out_vld, 1);
            chk($sformatf("bp_stall%0d_q16", k),      if16.q, 16'h0011);
            chk($sformatf("bp_stall%0d_q8", k),       if8.q, 8'h11);
            @(posedge clk); #1;
        end
        out_rdy = 1'b1;
        @(negedge clk);
        chk("bp_release_in_rdy", if16.in_rdy, 1);
        @(posedge clk); #1;
        in_vld = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk("bp_count16", got16.size(), 3);
        chk("bp_count8",  got8.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (got16.size() != 0) begin
                r16 = got16.pop_front();
                chk($sformatf("bp_order%0d_q16", k), r16[19:4], 16'h0011 * (k + 1));
            end
            if (got8.size() != 0) begin
                r8 = got8.pop_front();
                chk($sformatf("bp_order%0d_q8", k), r8[11:4], 8'h11 * (k + 1));
            end
        end

        // Reset with two ops in flight; the S1 op would write the accumulator if it survived
        got16.delete();
        got8.delete();
        @(posedge clk); #1;
        out_rdy = 1'b0; in_vld = 1'b1; s = T_PASS; b = 16'h0055; use_acc = 1'b0; acc_wr = 1'b0;
        @(posedge clk); #1;
        s = T_ADD; b = 16'h0005; use_acc = 1'b1; acc_wr = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("prerst_out_vld", if16.out_vld, 1);
        chk("prerst_q16",     if16.q, 16'h0055);
        chk("prerst_acc16",   if16.acc, 20);
        chk("prerst_in_rdy",  if16.in_rdy, 0);
        @(posedge clk); #1;
        rst = 1'b0; in_vld = 1'b0; out_rdy = 1'b1; use_acc = 1'b0; acc_wr = 1'b0;
        @(negedge clk);
        chk("postrst_out_vld16", if16.out_vld, 0);
        chk("postrst_out_vld8",  if8.out_vld, 0);
        chk("postrst_in_rdy16",  if16.in_rdy, 1);
        chk("postrst_in_rdy8",   if8.in_rdy, 1);
        chk("postrst_acc16",     if16.acc, 0);
        chk("postrst_acc8",      if8.acc, 0);
        chk("postrst_q16",       if16.q, 0);
        chk("postrst_flags16",   f16, 0);
        repeat (6) @(negedge clk);
        #1;
        chk("postrst_no_stale16", got16.size(), 0);
        chk("postrst_no_stale8",  got8.size(), 0);
        chk("postrst_acc16_hold", if16.acc, 0);
        chk("postrst_acc8_hold",  if8.acc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
